// File: rtl/clk_div_pkg.sv
// Default configuration constants and phase-width helper for the clock divider / scan sequencer.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned N_PHASE_DEF = 4;
    localparam int unsigned PH_W_DEF    = 3;
    localparam logic [CNT_W_DEF-1:0] DEFAULT_DIV_DEF = {CNT_W_DEF{1'b1}};

    // Minimum phase index width able to encode n phases.
    function automatic int unsigned min_ph_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scan_phase_seq.sv
// Scan phase counter with registered one-hot decode, advanced once per prescaler wrap.
module scan_phase_seq
    import clk_div_pkg::*;
#(
    parameter int unsigned N_PHASE = N_PHASE_DEF,
    parameter int unsigned PH_W    = PH_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    output logic [PH_W-1:0]    phase,
    output logic [N_PHASE-1:0] phase_onehot
);

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(N_PHASE - 1);

    // Phase index: wraps from the last digit back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (adv) begin
            if (phase == LAST_PHASE) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

    // One-hot decode kept as its own register so it changes on the same edge as phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_onehot <= N_PHASE'(1);
        end else if (adv) begin
            phase_onehot <= {phase_onehot[N_PHASE-2:0], phase_onehot[N_PHASE-1]};
        end
    end

endmodule

// File: rtl/clk_div_scan.sv
// Programmable prescaler with shadowed divide value driving a display scan phase sequencer.
module clk_div_scan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter int unsigned      N_PHASE     = N_PHASE_DEF,
    parameter int unsigned      PH_W        = PH_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = {CNT_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [CNT_W-1:0]   div_val,
    input  logic               div_load,
    output logic               tick,
    output logic [PH_W-1:0]    phase,
    output logic [N_PHASE-1:0] phase_onehot,
    output logic [CNT_W-1:0]   div_active,
    output logic               load_pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             tc;

    // Terminal count: the cycle whose following edge wraps the prescaler.
    assign tc = en && (cnt == div_active);

    // Prescaler and tick strobe; cnt can never pass div_active because it wraps on equality.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tc;
            if (tc) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shadowed divide value: new values take effect only at a wrap, a strobe on the wrap applies directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_active   <= DEFAULT_DIV;
            shadow       <= DEFAULT_DIV;
            load_pending <= 1'b0;
        end else if (tc && div_load) begin
            div_active   <= div_val;
            shadow       <= div_val;
            load_pending <= 1'b0;
        end else if (tc && load_pending) begin
            div_active   <= shadow;
            load_pending <= 1'b0;
        end else if (div_load) begin
            shadow       <= div_val;
            load_pending <= 1'b1;
        end
    end

    scan_phase_seq #(
        .N_PHASE (N_PHASE),
        .PH_W    (PH_W)
    ) u_phase (
        .clk          (clk),
        .reset        (reset),
        .adv          (tc),
        .phase        (phase),
        .phase_onehot (phase_onehot)
    );

endmodule

// File: tb/tb_clk_div_scan.sv
// Scoreboard bench for clk_div_scan with a cycle-level reference model plus directed scenario checks.
module tb_clk_div_scan;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned N_PHASE = 4;
    localparam int unsigned PH_W    = 3;
    localparam logic [CNT_W-1:0] DEFAULT_DIV = 4'd3;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [CNT_W-1:0]   div_val;
    logic               div_load;
    logic               tick;
    logic [PH_W-1:0]    phase;
    logic [N_PHASE-1:0] phase_onehot;
    logic [CNT_W-1:0]   div_active;
    logic               load_pending;

    int checks = 0;
    int errors = 0;

    // Expected {tick, phase, onehot, div_active, load_pending} after each edge.
    logic [12:0] sb_q[$];

    // Reference model state.
    logic [3:0] m_cnt;
    logic       m_tick;
    logic [2:0] m_phase;
    logic [3:0] m_act;
    logic [3:0] m_shadow;
    logic       m_pend;

    clk_div_scan #(
        .CNT_W       (CNT_W),
        .N_PHASE     (N_PHASE),
        .PH_W        (PH_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .div_val      (div_val),
        .div_load     (div_load),
        .tick         (tick),
        .phase        (phase),
        .phase_onehot (phase_onehot),
        .div_active   (div_active),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push its prediction, then compare after the edge.
    task automatic step(input logic e, input logic l, input logic [3:0] v, input logic r);
        logic        m_tc;
        logic [12:0] exp;
        logic [3:0]  oh;
        reset    = r;
        en       = e;
        div_load = l;
        div_val  = v;
        if (r) begin
            m_cnt = 4'd0; m_tick = 1'b0; m_phase = 3'd0;
            m_act = DEFAULT_DIV; m_shadow = DEFAULT_DIV; m_pend = 1'b0;
        end else begin
            m_tc   = e && (m_cnt == m_act);
            m_tick = m_tc;
            if (m_tc) begin
                m_cnt   = 4'd0;
                m_phase = 3'((32'(m_phase) + 1) % N_PHASE);
            end else if (e) begin
                m_cnt = m_cnt + 4'd1;
            end
            if (m_tc && l) begin
                m_act = v; m_shadow = v; m_pend = 1'b0;
            end else if (m_tc && m_pend) begin
                m_act = m_shadow; m_pend = 1'b0;
            end else if (l) begin
                m_shadow = v; m_pend = 1'b1;
            end
        end
        oh = 4'(1 << m_phase);
        sb_q.push_back({m_tick, m_phase, oh, m_act, m_pend});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(0), 32'(1));
        end else begin
            exp = sb_q.pop_front();
            chk("sb", 32'({tick, phase, phase_onehot, div_active, load_pending}), 32'(exp));
        end
    endtask

    // Free-run with en=1 and record the tick seen after each edge.
    task automatic run_en(input int n, output logic [15:0] pat);
        pat = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0);
            pat[i] = tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        logic [2:0]  held_phase;

        reset = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;

        // Reset state.
        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("rst_tick",   32'(tick),         32'(0));
        chk("rst_phase",  32'(phase),        32'(0));
        chk("rst_onehot", 32'(phase_onehot), 32'(4'b0001));
        chk("rst_div",    32'(div_active),   32'(3));
        chk("rst_pend",   32'(load_pending), 32'(0));

        // Default divide: tick every 4th cycle, phase wraps back to 0.
        run_en(16, pat);
        chk("div3_ticks",  32'(pat),          32'(16'h8888));
        chk("div3_phase",  32'(phase),        32'(0));
        chk("div3_onehot", 32'(phase_onehot), 32'(4'b0001));

        // Load 1 mid-period: pending until the current period ends.
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd1, 1'b0);
        chk("ld1_pend", 32'(load_pending), 32'(1));
        chk("ld1_hold", 32'(div_active),   32'(3));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("ld1_notick", 32'(tick), 32'(0));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("ld1_tick",  32'(tick),         32'(1));
        chk("ld1_apply", 32'(div_active),   32'(1));
        chk("ld1_clear", 32'(load_pending), 32'(0));
        run_en(6, pat);
        chk("div1_ticks", 32'(pat[5:0]), 32'(6'b101010));

        // Load 0 on the terminal count: applied at once, tick every cycle.
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 1'b0);
        chk("ld0_tick", 32'(tick),         32'(1));
        chk("ld0_div",  32'(div_active),   32'(0));
        chk("ld0_pend", 32'(load_pending), 32'(0));
        run_en(5, pat);
        chk("div0_ticks", 32'(pat[4:0]), 32'(5'b11111));

        // Back to divide 3, then pause at cnt=2 for 5 cycles while a load is captured and replaced.
        step(1'b1, 1'b1, 4'd3, 1'b0);
        chk("ld3_div", 32'(div_active), 32'(3));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        held_phase = phase;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i == 2), 4'd3, 1'b0);
            pat[i] = tick;
        end
        chk("pause_ticks", 32'(pat[4:0]), 32'(0));
        chk("pause_phase", 32'(phase),    32'(held_phase));
        chk("pause_pend",  32'(load_pending), 32'(1));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("resume_e1", 32'(tick), 32'(0));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("resume_e2", 32'(tick), 32'(1));
        chk("resume_pend", 32'(load_pending), 32'(0));

        // Pending load of 7 discarded by reset, which also overrides en and div_load.
        step(1'b1, 1'b1, 4'd7, 1'b0);
        chk("ld7_pend", 32'(load_pending), 32'(1));
        step(1'b1, 1'b1, 4'd7, 1'b1);
        chk("rst2_div",  32'(div_active),   32'(3));
        chk("rst2_pend", 32'(load_pending), 32'(0));
        chk("rst2_tick", 32'(tick),         32'(0));
        run_en(8, pat);
        chk("rst2_ticks", 32'(pat[7:0]), 32'(8'b10001000));

        // Two loads before the wrap: only the latest applies, once.
        step(1'b1, 1'b1, 4'd5, 1'b0);
        step(1'b1, 1'b1, 4'd2, 1'b0);
        chk("dbl_pend", 32'(load_pending), 32'(1));
        chk("dbl_hold", 32'(div_active),   32'(3));
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("dbl_tick",  32'(tick),         32'(1));
        chk("dbl_apply", 32'(div_active),   32'(2));
        run_en(6, pat);
        chk("div2_ticks", 32'(pat[5:0]), 32'(6'b100100));
        chk("div2_div",   32'(div_active),   32'(2));
        chk("div2_pend",  32'(load_pending), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
